hazard_ctrl: RTL

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 75 +++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-stage stall/flush FSM for load-use and control-transfer hazards.
// Define HAZARD_PERF_CNT_EN to add the stall_cycles/flush_count performance counters.
module hazard_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       rs1_used,
  input  logic       rs2_used,
  input  logic [2:0] NPCOp,
  input  logic [4:0] ID_EX_rd,
  input  logic       ID_EX_RegWrite,
  input  logic       ID_EX_MemRead,
  input  logic [4:0] EX_MEM_rd,
  input  logic       EX_MEM_MemRead,
  input  logic       branch_taken,
  output logic       PCWrite,
  output logic       IF_ID_Write,
  output logic       ID_EX_Bubble,
  output logic       IF_ID_Flush,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic [1:0] stall_state
);
  localparam logic [2:0] NPC_BRANCH = 3'b001;
  localparam logic [2:0] NPC_JALR   = 3'b100;
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] STALL1 = 2'd1;
  localparam logic [1:0] STALL2 = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;
  logic [1:0] state_q, state_d;
  logic ct, m_ex, m_mem, lu, ab, lb, lb2, haz, stall, flush;
  always_comb begin
    ct    = (NPCOp == NPC_BRANCH) || (NPCOp == NPC_JALR);
    m_ex  = (ID_EX_rd != 5'd0) && ((rs1_used && ID_EX_rd == rs1) || (rs2_used && ID_EX_rd == rs2));
    m_mem = (EX_MEM_rd != 5'd0) && ((rs1_used && EX_MEM_rd == rs1) || (rs2_used && EX_MEM_rd == rs2));
    lu    = ID_EX_MemRead && m_ex && !ct;
    ab    = ID_EX_RegWrite && !ID_EX_MemRead && m_ex && ct;
    lb    = ID_EX_MemRead && m_ex && ct;
    lb2   = EX_MEM_MemRead && m_mem && ct;
    // Detection only in IDLE; STALL1 is the final hazard-free ID cycle
    haz   = !rst && state_q == IDLE && (lu || ab || lb || lb2);
    stall = haz || (!rst && state_q == STALL2);
    flush = !rst && !haz && branch_taken && (state_q == IDLE || state_q == STALL1);
    PCWrite      = !stall;
    IF_ID_Write  = !stall;
    ID_EX_Bubble = stall;
    IF_ID_Flush  = flush;
    state_d = rst                ? IDLE :
              state_q == STALL2  ? STALL1 :
              state_q == FLUSH   ? IDLE :
              flush              ? FLUSH :
              state_q == STALL1  ? IDLE :
              haz && lb          ? STALL2 :
              haz                ? STALL1 : IDLE;
  end
  always_ff @(posedge clk) state_q <= state_d;
  assign stall_state = state_q;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_q, flush_count_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_q + {31'd0, ID_EX_Bubble};
      flush_count_q  <= flush_count_q + {31'd0, IF_ID_Flush};
    end
  end
  assign stall_cycles = stall_cycles_q;
  assign flush_count  = flush_count_q;
`endif
endmodule
